// File: rtl/lsq_pkg.sv
// Shared sizing and entry layout for the load/store queue store buffer.
package lsq_pkg;

    localparam int unsigned SFB_DEPTH  = 4;
    localparam int unsigned LSQ_ADDR_W = 16;
    localparam int unsigned LSQ_DATA_W = 16;
    localparam int unsigned SFB_PTR_W  = $clog2(SFB_DEPTH);
    localparam int unsigned SFB_CNT_W  = SFB_PTR_W + 1;

    typedef struct packed {
        logic                  valid;
        logic [LSQ_ADDR_W-1:0] addr;
        logic [LSQ_DATA_W-1:0] data;
    } sfb_entry_t;

endpackage

// File: rtl/sfb_match_select.sv
// Youngest-match selector for store-to-load forwarding, with same-cycle store bypass.
module sfb_match_select
    import lsq_pkg::*;
(
    input  sfb_entry_t [SFB_DEPTH-1:0] entries,
    input  logic [SFB_PTR_W-1:0]       head,
    input  logic [LSQ_ADDR_W-1:0]      ld_addr,
    input  logic                       byp_valid,
    input  logic [LSQ_ADDR_W-1:0]      byp_addr,
    input  logic [LSQ_DATA_W-1:0]      byp_data,
    output logic                       hit_c,
    output logic [LSQ_DATA_W-1:0]      data_c
);

    // Walk oldest to youngest so later matches overwrite; the incoming store is youngest of all.
    always_comb begin
        logic [SFB_PTR_W-1:0] idx;
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        for (int k = 0; k < SFB_DEPTH; k++) begin
            idx = head + SFB_PTR_W'(k);
            if (entries[idx].valid && (entries[idx].addr == ld_addr)) begin
                hit_c  = 1'b1;
                data_c = entries[idx].data;
            end
        end
        if (byp_valid && (byp_addr == ld_addr)) begin
            hit_c  = 1'b1;
            data_c = byp_data;
        end
    end

endmodule

// File: rtl/store_forward_buffer.sv
// Committed-store buffer: in-order drain to memory and youngest-match forwarding to loads.
module store_forward_buffer
    import lsq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    input  logic [LSQ_ADDR_W-1:0] st_addr,
    input  logic [LSQ_DATA_W-1:0] st_data,
    output logic                  st_ready,
    input  logic                  ld_valid,
    input  logic [LSQ_ADDR_W-1:0] ld_addr,
    output logic                  fwd_valid,
    output logic                  fwd_hit,
    output logic [LSQ_DATA_W-1:0] fwd_data,
    output logic                  mem_wr_en,
    output logic [LSQ_ADDR_W-1:0] mem_wr_addr,
    output logic [LSQ_DATA_W-1:0] mem_wr_data,
    input  logic                  mem_wr_ack,
    output logic [SFB_CNT_W-1:0]  count
);

    sfb_entry_t [SFB_DEPTH-1:0] entries;
    logic [SFB_PTR_W-1:0]       head;
    logic [SFB_PTR_W-1:0]       tail;
    logic                       enq;
    logic                       deq;
    logic                       match_hit;
    logic [LSQ_DATA_W-1:0]      match_data;

    // Ready and drain status come from registered occupancy only, so a drain never frees a slot early.
    assign st_ready    = (count != SFB_CNT_W'(SFB_DEPTH));
    assign mem_wr_en   = (count != '0);
    assign mem_wr_addr = entries[head].addr;
    assign mem_wr_data = entries[head].data;
    assign enq         = st_valid && st_ready;
    assign deq         = mem_wr_ack && mem_wr_en;

    // Entry storage: write at tail on enqueue, retire head on drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries <= '0;
        end else begin
            if (enq) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
            end
            if (deq) begin
                entries[head].valid <= 1'b0;
            end
        end
    end

    // Circular pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + SFB_PTR_W'(1);
            if (deq) head <= head + SFB_PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + SFB_CNT_W'(1);
                2'b01:   count <= count - SFB_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    sfb_match_select u_match (
        .entries   (entries),
        .head      (head),
        .ld_addr   (ld_addr),
        .byp_valid (enq),
        .byp_addr  (st_addr),
        .byp_data  (st_data),
        .hit_c     (match_hit),
        .data_c    (match_data)
    );

    // Lookup result registered one cycle after the request; data is zero on a miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_valid <= 1'b0;
            fwd_hit   <= 1'b0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= ld_valid;
            fwd_hit   <= ld_valid && match_hit;
            fwd_data  <= (ld_valid && match_hit) ? match_data : '0;
        end
    end

endmodule

// File: doc/store_forward_buffer.md
Name: store_forward_buffer

Overview:
- Store side of the load/store queue: buffers committed stores in program order and drains them to data memory one per handshake.
- Answers load lookups with the youngest matching store's data. Feeds the forwarded-data input of the load stage.
- Provides an explicit hit flag, so a stored value of 16'h0000 forwards correctly. The load stage qualifies forwarded data with fwd_hit, never with the data value.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  store enqueue request.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load lookup request.
- ld_addr  in  ADDR_W  load address to match.
- fwd_valid  out  1  lookup result valid; registered, one cycle after ld_valid.
- fwd_hit  out  1  a matching store was found.
- fwd_data  out  DATA_W  youngest matching store data; 0 when fwd_hit=0.
- mem_wr_en  out  1  head entry presented to memory.
- mem_wr_addr  out  ADDR_W  head entry address.
- mem_wr_data  out  DATA_W  head entry data.
- mem_wr_ack  in  1  memory accepted head entry this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage:
  - Circular array of {valid, addr, data} entries with head, tail and count registers.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous):
  - All entry valid bits cleared; head=tail=count=0.
  - fwd_valid=0, fwd_hit=0, fwd_data=0.
  - mem_wr_en=0 (empty), st_ready=1.
  - A reset mid-drain discards all buffered stores.
- Enqueue:
  - st_ready = (count != DEPTH), computed from registered count only.
  - At full, a same-cycle drain does not free a slot for that cycle's enqueue.
  - On st_valid && st_ready: write entry[tail], set its valid bit, tail+1.
  - st_valid while not ready is ignored; the producer must hold its request.
- Drain:
  - mem_wr_en = (count != 0), combinational from state.
  - mem_wr_addr/mem_wr_data = entry[head], stable while unacked.
  - On mem_wr_ack && mem_wr_en: clear entry[head] valid, head+1.
  - mem_wr_ack while empty is ignored.
- Count:
  - +1 on enqueue only, −1 on drain only.
  - Unchanged on simultaneous enqueue and drain (legal whenever 0 < count < DEPTH).
- Lookup:
  - Compare ld_addr with every valid entry, including the head being acked that same cycle.
  - Select the youngest match by age order (tail−1 back toward head).
  - Same-cycle bypass: if a store is accepted this cycle and st_addr == ld_addr, it is youngest and its st_data wins.
  - Result registered next edge: fwd_valid <= ld_valid; fwd_hit <= match && ld_valid; fwd_data <= selected data, else 0.
  - Lookup latency is exactly 1 cycle. Back-to-back lookups are supported every cycle.
  - Lookups never change buffer state.
- Matching: full-width address equality; no partial or byte overlap.

Decomposition:
- Shared package (lsq_pkg):
  - SFB_DEPTH, LSQ_ADDR_W, LSQ_DATA_W.
  - Entry typedef {valid, addr, data}.
  - Pointer width constant.
- Sub-module sfb_match_select:
  - Combinational; takes the entry array, head, ld_addr and the bypass inputs.
  - Returns {hit, data} for the youngest match.
  - Top level keeps the pointers, storage and output registers.

Test Plan:
- Reset, then ld_valid with ld_addr=16'h0040 → next cycle fwd_valid=1, fwd_hit=0, fwd_data=0; mem_wr_en=0, st_ready=1, count=0.
- Enqueue 16'h0040→16'h1111 then 16'h0040→16'h2222, no ack; lookup 16'h0040 → fwd_hit=1, fwd_data=16'h2222 (youngest).
- Enqueue 16'h0080→16'h0000; lookup 16'h0080 → fwd_hit=1, fwd_data=16'h0000 (zero data still forwards).
- Fill 4 stores → st_ready=0, count=4. Assert st_valid plus mem_wr_ack in one cycle → store not accepted, count=3. Next cycle st_ready=1 and the enqueue succeeds; tail wrap verified.
- Same cycle: st_valid with 16'h00C0→16'hBEEF accepted and ld_valid 16'h00C0 → next cycle fwd_hit=1, fwd_data=16'hBEEF (bypass).
- Two stores queued, ack the first → mem_wr_addr/mem_wr_data advance to the second. Assert reset mid-operation → count=0, mem_wr_en=0, fwd_valid=0 immediately.
